// File: rtl/inst_fetch_unit.sv
// IF stage: owns the PC, addresses the instruction ROM and fills the IF/ID register.
// Redirects squash wrong-path fetches into bubbles; stalls freeze the stage.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_INST     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        squashing,
  output logic [15:0] flush_count
);

  typedef enum logic [0:0] {StRun, StSquash} state_e;

  localparam logic [2:0] SquashLen = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [15:0] flush_q, flush_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // The branch sits in EX and is older, so a simultaneous ID jump is on its wrong path.
  assign redirect = branch_taken | jump;
  assign target   = branch_taken ? branch_target : jump_target;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    flush_d = flush_q;

    if (redirect) begin
      pc_d    = target;
      inst_d  = NOP_INST;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
      flush_d = (flush_q == 16'hFFFF) ? flush_q : flush_q + 16'd1;
      if (FLUSH_CYCLES > 1) begin
        state_d = StSquash;
        cnt_d   = SquashLen;
      end else begin
        state_d = StRun;
        cnt_d   = 3'd0;
      end
    end else if (!stall) begin
      pc_d = pc_plus4;
      unique case (state_q)
        StRun: begin
          inst_d  = rom_inst;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
        end
        StSquash: begin
          inst_d  = NOP_INST;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
          cnt_d   = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= 3'd0;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      flush_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
    end
  end

  assign rom_addr    = pc_q;
  assign if_id_inst  = inst_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign squashing   = (state_q == StSquash);
  assign flush_count = flush_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a single-bubble and a three-bubble instance share
// stimulus; expectations are queued per step and checked after each rising edge.
module tb_inst_fetch_unit;

  localparam int MAddr = 1;
  localparam int MInst = 2;
  localparam int MPc4  = 4;
  localparam int MVal  = 8;
  localparam int MSq   = 16;
  localparam int MFc   = 32;
  localparam int MAll  = 63;

  typedef struct {
    string       tag;
    int          which;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic        sq;
    logic [15:0] fc;
    int          mask;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target;

  logic [31:0] a1, ri1, i1, p1;
  logic        v1, s1;
  logic [15:0] f1;
  logic [31:0] a3, ri3, i3, p3;
  logic        v3, s3;
  logic [15:0] f3;

  logic [31:0] rom [64];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign ri1 = rom[a1[7:2]];
  assign ri3 = rom[a3[7:2]];

  inst_fetch_unit #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .rom_addr(a1), .rom_inst(ri1),
    .if_id_inst(i1), .if_id_pc4(p1), .if_id_valid(v1),
    .squashing(s1), .flush_count(f1)
  );

  inst_fetch_unit #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .rom_addr(a3), .rom_inst(ri3),
    .if_id_inst(i3), .if_id_pc4(p3), .if_id_valid(v3),
    .squashing(s3), .flush_count(f3)
  );

  task automatic cmp(string tag, string fld, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic want(string tag, int which, logic [31:0] addr, logic [31:0] inst,
                      logic [31:0] pc4, logic valid, logic sq, logic [15:0] fc, int mask);
    exp_t e;
    e.tag = tag; e.which = which; e.addr = addr; e.inst = inst; e.pc4 = pc4;
    e.valid = valid; e.sq = sq; e.fc = fc; e.mask = mask;
    sb.push_back(e);
  endtask

  // Advance one edge, then drain every expectation queued for that edge.
  task automatic tick();
    exp_t        e;
    logic [31:0] oa, oi, op;
    logic        ov, os;
    logic [15:0] of;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.which == 3) begin
        oa = a3; oi = i3; op = p3; ov = v3; os = s3; of = f3;
      end else begin
        oa = a1; oi = i1; op = p1; ov = v1; os = s1; of = f1;
      end
      if ((e.mask & MAddr) != 0) cmp(e.tag, "rom_addr", oa, e.addr);
      if ((e.mask & MInst) != 0) cmp(e.tag, "if_id_inst", oi, e.inst);
      if ((e.mask & MPc4) != 0)  cmp(e.tag, "if_id_pc4", op, e.pc4);
      if ((e.mask & MVal) != 0)  cmp(e.tag, "if_id_valid", {31'd0, ov}, {31'd0, e.valid});
      if ((e.mask & MSq) != 0)   cmp(e.tag, "squashing", {31'd0, os}, {31'd0, e.sq});
      if ((e.mask & MFc) != 0)   cmp(e.tag, "flush_count", {16'd0, of}, {16'd0, e.fc});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 + i * 32'h0001_0101;
    rom[1]  = 32'h0010_0443;
    rom[2]  = 32'h0420_1021;
    rom[3]  = 32'h0420_18E1;
    rom[17] = 32'h4800_0007;

    // Reset wins over stall and a taken branch.
    rst = 1; stall = 1; branch_taken = 1; branch_target = 32'h80;
    jump = 0; jump_target = 32'h0;
    tick();
    want("reset", 1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0, MAll);
    want("reset3", 3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0, MAll);
    tick();

    rst = 0; stall = 0; branch_taken = 0;
    want("rel1", 1, 32'h4, 32'h0, 32'h4, 1'b1, 1'b0, 16'd0, MAddr | MPc4 | MVal);
    tick();
    want("rel2", 1, 32'h8, 32'h0010_0443, 32'h8, 1'b1, 1'b0, 16'd0, MAll);
    tick();
    want("rel3", 1, 32'hC, 32'h0420_1021, 32'hC, 1'b1, 1'b0, 16'd0, MAll);
    tick();

    stall = 1;
    for (int k = 0; k < 3; k++) begin
      want("stall", 1, 32'hC, 32'h0420_1021, 32'hC, 1'b1, 1'b0, 16'd0, MAll);
      tick();
    end
    stall = 0;
    want("unstall", 1, 32'h10, 32'h0420_18E1, 32'h10, 1'b1, 1'b0, 16'd0, MAll);
    tick();

    for (int k = 1; k <= 4; k++) begin
      want("run", 1, 32'h10 + 32'(4 * k), 32'h0, 32'h10 + 32'(4 * k), 1'b1, 1'b0, 16'd0,
           MAddr | MPc4 | MVal);
      tick();
    end

    branch_taken = 1; branch_target = 32'h44;
    want("branch", 1, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0, 16'd1, MAll);
    tick();
    branch_taken = 0;
    want("branch_tgt", 1, 32'h48, 32'h4800_0007, 32'h48, 1'b1, 1'b0, 16'd1, MAll);
    tick();

    branch_taken = 1; branch_target = 32'h44; jump = 1; jump_target = 32'h10; stall = 1;
    want("simul", 1, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0, 16'd2, MAll);
    tick();
    branch_taken = 0; stall = 0;
    want("jump", 1, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 16'd3, MAll);
    tick();
    jump = 0;
    want("jump_tgt", 1, 32'h14, rom[4], 32'h14, 1'b1, 1'b0, 16'd3, MAll);
    tick();

    // Three-bubble instance.
    rst = 1;
    want("rst3", 3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0, MAll);
    tick();
    rst = 0;
    want("run3", 3, 32'h4, 32'h0, 32'h4, 1'b1, 1'b0, 16'd0, MAddr | MPc4 | MVal);
    tick();
    branch_taken = 1; branch_target = 32'h44;
    want("sq_a", 3, 32'h44, 32'h0, 32'h0, 1'b0, 1'b1, 16'd1, MAll);
    tick();
    branch_taken = 0;
    want("sq_b", 3, 32'h48, 32'h0, 32'h0, 1'b0, 1'b1, 16'd1, MAll);
    tick();
    want("sq_c", 3, 32'h4C, 32'h0, 32'h0, 1'b0, 1'b0, 16'd1, MAll);
    tick();
    want("sq_end", 3, 32'h50, rom[19], 32'h50, 1'b1, 1'b0, 16'd1, MAll);
    tick();

    branch_taken = 1;
    want("sqst_a", 3, 32'h44, 32'h0, 32'h0, 1'b0, 1'b1, 16'd2, MAll);
    tick();
    branch_taken = 0; stall = 1;
    for (int k = 0; k < 2; k++) begin
      want("sqst_hold", 3, 32'h44, 32'h0, 32'h0, 1'b0, 1'b1, 16'd2, MAll);
      tick();
    end
    stall = 0;
    want("sqst_b", 3, 32'h48, 32'h0, 32'h0, 1'b0, 1'b1, 16'd2, MAll);
    tick();
    want("sqst_c", 3, 32'h4C, 32'h0, 32'h0, 1'b0, 1'b0, 16'd2, MAll);
    tick();
    want("sqst_end", 3, 32'h50, rom[19], 32'h50, 1'b1, 1'b0, 16'd2, MAll);
    tick();

    branch_taken = 1;
    want("sqrst_a", 3, 32'h44, 32'h0, 32'h0, 1'b0, 1'b1, 16'd3, MAll);
    tick();
    branch_taken = 0; rst = 1;
    want("sqrst", 3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0, MAll);
    want("sqrst1", 1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0, MAll);
    tick();
    rst = 0;

    // Redirect every cycle to drive flush_count into saturation.
    branch_taken = 1; branch_target = 32'h100;
    repeat (16'hFFFD) @(posedge clk);
    want("sat_pre", 1, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 16'hFFFE, MAll);
    tick();
    for (int k = 0; k < 3; k++) begin
      want("sat", 1, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 16'hFFFF, MAll);
      want("sat3", 3, 32'h100, 32'h0, 32'h0, 1'b0, 1'b1, 16'hFFFF, MAll);
      tick();
    end
    branch_taken = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
